// File: rtl/definitions_pkg.sv
// Shared pipeline definitions: ALU operation encoding from the decoder.
// Values outside the enumerated set are treated as "no operation".
package definitions_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_SH0ADD = 4'd10,
        ALU_SH1ADD = 4'd11,
        ALU_SH2ADD = 4'd12,
        ALU_SH3ADD = 4'd13
    } alu_e;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational integer ALU: RV32I/RV64I base ops, RV64 word forms,
// Zba shift-add with optional .uw zero-extension of rs1.
module alu
    import definitions_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_e             op_i,
    input  logic             word_i,
    input  logic             uw_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic [XLEN-1:0]  result_o
);

    logic            w_word;
    logic            w_word_op;
    logic [5:0]      w_sh;
    logic [XLEN-1:0] w_ap;
    logic [31:0]     w_wr;
    logic [XLEN-1:0] w_full;

    assign w_word = word_i && (XLEN == 64);
    assign w_ap   = uw_i ? XLEN'(a_i[31:0]) : a_i;

    // Sixth shift bit only exists for full-width RV64 shifts
    always_comb begin
        w_sh = {1'b0, b_i[4:0]};
        if (XLEN == 64 && !w_word) w_sh[5] = b_i[5];
    end

    assign w_word_op = w_word && (op_i inside
        {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA});

    always_comb begin
        w_wr = '0;
        case (op_i)
            ALU_ADD: w_wr = a_i[31:0] + b_i[31:0];
            ALU_SUB: w_wr = a_i[31:0] - b_i[31:0];
            ALU_SLL: w_wr = a_i[31:0] << w_sh[4:0];
            ALU_SRL: w_wr = a_i[31:0] >> w_sh[4:0];
            ALU_SRA: w_wr = $unsigned($signed(a_i[31:0]) >>> w_sh[4:0]);
            default: w_wr = '0;
        endcase
    end

    always_comb begin
        w_full = '0;
        case (op_i)
            ALU_ADD:    w_full = a_i + b_i;
            ALU_SUB:    w_full = a_i - b_i;
            ALU_AND:    w_full = a_i & b_i;
            ALU_OR:     w_full = a_i | b_i;
            ALU_XOR:    w_full = a_i ^ b_i;
            ALU_SLT:    w_full = XLEN'($signed(a_i) < $signed(b_i));
            ALU_SLTU:   w_full = XLEN'(a_i < b_i);
            ALU_SLL:    w_full = a_i << w_sh;
            ALU_SRL:    w_full = a_i >> w_sh;
            ALU_SRA:    w_full = $unsigned($signed(a_i) >>> w_sh);
            ALU_SH0ADD: w_full = w_ap + b_i;
            ALU_SH1ADD: w_full = (w_ap << 1) + b_i;
            ALU_SH2ADD: w_full = (w_ap << 2) + b_i;
            ALU_SH3ADD: w_full = (w_ap << 3) + b_i;
            default:    w_full = '0;
        endcase
    end

    assign result_o = w_word_op ? XLEN'(signed'(w_wr)) : w_full;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX operand slot and EX/MEM result slot behind
// valid/ready handshakes; 2-cycle latency, full throughput, flush.
module ex_stage
    import definitions_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  alu_e             alu_control_i,
    input  logic             word_i,
    input  logic             uw_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic             zero_o,
    output logic [4:0]       rd_o
);

    logic            r_v1;
    logic            r_v2;
    alu_e            r_op;
    logic            r_word;
    logic            r_uw;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd1;
    logic [XLEN-1:0] r_res;
    logic            r_zero;
    logic [4:0]      r_rd2;

    logic            w_s1_load;
    logic            w_s2_load;
    logic [XLEN-1:0] w_res;

    assign w_s2_load  = r_v1 & (~r_v2 | out_ready_i);
    assign in_ready_o = ~r_v1 | w_s2_load;
    assign w_s1_load  = in_valid_i & in_ready_o;

    alu #(.XLEN(XLEN)) u_alu (
        .op_i     (r_op),
        .word_i   (r_word),
        .uw_i     (r_uw),
        .a_i      (r_a),
        .b_i      (r_b),
        .result_o (w_res)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (flush_i) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_s1_load)      r_v1 <= 1'b1;
            else if (w_s2_load) r_v1 <= 1'b0;
            if (w_s2_load)        r_v2 <= 1'b1;
            else if (out_ready_i) r_v2 <= 1'b0;
        end
    end

    // Data regs may load during flush; the cleared valids mask them
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op   <= ALU_ADD;
            r_word <= 1'b0;
            r_uw   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_rd1  <= '0;
        end else if (w_s1_load) begin
            r_op   <= alu_control_i;
            r_word <= word_i;
            r_uw   <= uw_i;
            r_a    <= a_i;
            r_b    <= b_i;
            r_rd1  <= rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res  <= '0;
            r_zero <= 1'b0;
            r_rd2  <= '0;
        end else if (w_s2_load) begin
            r_res  <= w_res;
            r_zero <= (w_res == '0);
            r_rd2  <= r_rd1;
        end
    end

    assign out_valid_o = r_v2;
    assign result_o    = r_res;
    assign zero_o      = r_zero;
    assign rd_o        = r_rd2;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage (XLEN=64) against a queue-based
// transaction model with an arithmetic ALU reference.
module tb_ex_stage;
    import definitions_pkg::*;

    localparam int XLEN = 64;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    alu_e              alu_control_i = ALU_ADD;
    logic              word_i = 1'b0;
    logic              uw_i = 1'b0;
    logic [XLEN-1:0]   a_i = '0;
    logic [XLEN-1:0]   b_i = '0;
    logic [4:0]        rd_i = '0;
    logic              flush_i = 1'b0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [XLEN-1:0]   result_o;
    logic              zero_o;
    logic [4:0]        rd_o;

    ex_stage #(.XLEN(XLEN)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .alu_control_i (alu_control_i),
        .word_i        (word_i),
        .uw_i          (uw_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .rd_i          (rd_i),
        .flush_i       (flush_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .result_o      (result_o),
        .zero_o        (zero_o),
        .rd_o          (rd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          age;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_out = 0;
    bit   stall_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] op,
        input bit w, input bit u, input logic [63:0] a, input logic [63:0] b);
        longint          sa = a;
        longint          sb = b;
        int              wa = a[31:0];
        int              wb = b[31:0];
        int unsigned     wu = a[31:0];
        int unsigned     sh = w ? 32'(b[4:0]) : 32'(b[5:0]);
        logic [63:0]     ap = u ? {32'b0, a[31:0]} : a;
        int              r;
        alu_e            e = alu_e'(op);
        if (w && (e inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA})) begin
            case (e)
                ALU_ADD: r = wa + wb;
                ALU_SUB: r = wa - wb;
                ALU_SLL: r = wa << sh;
                ALU_SRL: r = int'(wu >> sh);
                default: r = wa >>> sh;
            endcase
            return 64'(longint'(r));
        end
        case (e)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLT:    return (sa < sb) ? 64'd1 : 64'd0;
            ALU_SLTU:   return (a < b) ? 64'd1 : 64'd0;
            ALU_SLL:    return a << sh;
            ALU_SRL:    return a >> sh;
            ALU_SRA:    return 64'(sa >>> sh);
            ALU_SH0ADD: return ap + b;
            ALU_SH1ADD: return ap * 64'd2 + b;
            ALU_SH2ADD: return ap * 64'd4 + b;
            ALU_SH3ADD: return ap * 64'd8 + b;
            default:    return 64'd0;
        endcase
    endfunction

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input bit iv, input logic [3:0] op, input bit w,
        input bit u, input logic [63:0] a, input logic [63:0] b,
        input logic [4:0] rd, input bit ordy, input bit fl, output bit acc);
        exp_t e;
        bit   ev;
        bit   er;
        @(negedge clk_i);
        in_valid_i    = iv;
        alu_control_i = alu_e'(op);
        word_i        = w;
        uw_i          = u;
        a_i           = a;
        b_i           = b;
        rd_i          = rd;
        out_ready_i   = ordy;
        flush_i       = fl;
        #1;
        ev = (q.size() > 0) && (q[0].age > 0);
        check("out_valid", out_valid_o, 64'(ev));
        if (ev) begin
            check("result", result_o, q[0].res);
            check("rd", rd_o, 64'(q[0].rd));
            check("zero", zero_o, 64'(q[0].res == 64'd0));
        end
        er = !(q.size() == 2 && !ordy);
        check("in_ready", in_ready_o, 64'(er));
        if (!er) stall_seen = 1;
        acc = iv && er && !fl;
        @(posedge clk_i);
        if (fl) begin
            q.delete();
        end else begin
            if (ev && ordy) begin
                void'(q.pop_front());
                n_out++;
            end
            foreach (q[i]) q[i].age++;
            if (acc) begin
                e.res = ref_alu(op, w, u, a, b);
                e.rd  = rd;
                e.age = 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        cycle(0, 4'd0, 0, 0, 64'd0, 64'd0, 5'd0, ordy, 0, acc);
    endtask

    task automatic run_one(input string tag, input alu_e op, input bit w,
        input bit u, input logic [63:0] a, input logic [63:0] b,
        input logic [4:0] rd, input logic [63:0] expv);
        bit acc;
        cycle(1, op, w, u, a, b, rd, 1, 0, acc);
        idle(0);
        idle(0);
        #1;
        check({tag, "_valid"}, out_valid_o, 64'd1);
        check(tag, result_o, expv);
        check({tag, "_zero"}, zero_o, 64'(expv == 64'd0));
        check({tag, "_rd"}, rd_o, 64'(rd));
        idle(1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() > 0; k++) idle(1);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return 64'($urandom_range(0, 70));
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return {32'($urandom), 32'h8000_0000};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        int          i;
        int          cyc;
        int          out0;
        logic [3:0]  op;

        #12;
        check("rst_out_valid", out_valid_o, 64'd0);
        check("rst_in_ready", in_ready_o, 64'd1);
        check("rst_result", result_o, 64'd0);
        check("rst_zero", zero_o, 64'd0);
        check("rst_rd", rd_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_one("add", ALU_ADD, 0, 0, 64'd5, 64'd7, 5'd3, 64'd12);
        run_one("sub_zero", ALU_SUB, 0, 0, 64'h10, 64'h10, 5'd4, 64'd0);
        run_one("addw", ALU_ADD, 1, 0, 64'h7FFF_FFFF, 64'd1, 5'd5,
                64'hFFFF_FFFF_8000_0000);
        run_one("sraw", ALU_SRA, 1, 0, 64'h8000_0000, 64'd4, 5'd6,
                64'hFFFF_FFFF_F800_0000);
        run_one("sh2add_uw", ALU_SH2ADD, 0, 1, 64'hFFFF_FFFF_0000_0003,
                64'd1, 5'd7, 64'hD);
        run_one("slt", ALU_SLT, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                5'd8, 64'd1);
        run_one("sltu", ALU_SLTU, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                5'd9, 64'd0);
        run_one("srl64", ALU_SRL, 0, 0, 64'h8000_0000_0000_0000, 64'd63,
                5'd10, 64'd1);
        run_one("unknown", alu_e'(4'hF), 0, 0, 64'd9, 64'd9, 5'd11, 64'd0);

        // 8 back-to-back ops with a 3-cycle sink stall mid-stream
        out0 = n_out;
        stall_seen = 0;
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 40) begin
            cycle(1, 4'(i % 14), 0, 0, 64'(i * 3 + 1), 64'(i + 100),
                  5'(i + 16), !(cyc >= 3 && cyc <= 5), 0, acc);
            if (acc) i++;
            cyc++;
        end
        drain();
        check("bp_outputs", 64'(n_out - out0), 64'd8);
        check("bp_stall_seen", 64'(stall_seen), 64'd1);

        // Flush with both slots full and a same-cycle input handshake
        cycle(1, ALU_ADD, 0, 0, 64'd1, 64'd1, 5'd1, 0, 0, acc);
        cycle(1, ALU_ADD, 0, 0, 64'd2, 64'd2, 5'd2, 0, 0, acc);
        idle(0);
        cycle(1, ALU_ADD, 0, 0, 64'd3, 64'd3, 5'd3, 1, 1, acc);
        #1;
        check("flush_valid", out_valid_o, 64'd0);
        for (int k = 0; k < 4; k++) idle(1);

        // Asynchronous reset mid-stream
        cycle(1, ALU_OR, 0, 0, 64'hF0, 64'h0F, 5'd12, 0, 0, acc);
        cycle(1, ALU_XOR, 0, 0, 64'hF0, 64'h0F, 5'd13, 0, 0, acc);
        idle(0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_out_valid", out_valid_o, 64'd0);
        check("arst_result", result_o, 64'd0);
        check("arst_rd", rd_o, 64'd0);
        check("arst_in_ready", in_ready_o, 64'd1);
        q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) idle(1);

        for (int k = 0; k < 1500; k++) begin
            op = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 3) != 0, op, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, rand_operand(), rand_operand(),
                  5'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
